// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - assembles narrow host pipe words into one wide parameter word
//
// Collects inwidth-bit input words, little-endian, into a bitwidth-bit word.
// When the last word arrives, out_data is loaded and out_set pulses for one cycle.
// Optional idle timeout abandons a stalled partial word: define ASSEMBLER_TIMEOUT_EN.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high
//   in_valid   in   in_data holds a valid word
//   in_data    in   [inwidth-1:0] input word
//   sync       in   start-of-record, restart at word 0
//   out_data   out  [bitwidth-1:0] last completed word
//   out_set    out  one-cycle strobe, out_data new
//   busy       out  partial word held
//   word_idx   out  index of next expected input word
//   frag_error out  sticky, a partial word was discarded

module word_assembler #(
  parameter int bitwidth = 24,
  parameter int inwidth  = 16,
  parameter int timeout  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [inwidth-1:0]  in_data,
  input  logic                sync,
  output logic [bitwidth-1:0] out_data,
  output logic                out_set,
  output logic                busy,
  output logic [((bitwidth+inwidth-1)/inwidth > 1 ? $clog2((bitwidth+inwidth-1)/inwidth) : 1)-1:0] word_idx,
  output logic                frag_error
);

  localparam int NWORDS = (bitwidth + inwidth - 1) / inwidth;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  logic [bitwidth-1:0] acc_q, acc_d;
  logic [bitwidth-1:0] out_data_q, out_data_d;
  logic                out_set_q, out_set_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                frag_q, frag_d;

  logic [IDXW-1:0]     eff_idx;
  logic [bitwidth-1:0] base_acc;
  logic [bitwidth-1:0] in_ext;
  logic [bitwidth-1:0] slice;
  logic [bitwidth-1:0] merged;

  // sync makes the incoming word (if any) word 0 of a fresh record.
  always_comb begin
    eff_idx  = sync ? '0 : idx_q;
    base_acc = sync ? '0 : acc_q;
    in_ext   = '0;
    in_ext[inwidth-1:0] = in_data;
    // Shifting within bitwidth bits drops the unused upper bits of the last word.
    slice    = in_ext << (eff_idx * inwidth);
    merged   = base_acc | slice;
  end

`ifdef ASSEMBLER_TIMEOUT_EN
  localparam int CNTW = $clog2(timeout + 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            expire;

  always_comb begin
    cnt_d  = '0;
    expire = 1'b0;
    if (!in_valid && !sync && (idx_q != '0)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNTW'(timeout)) begin
        cnt_d  = '0;
        expire = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic expire;
  assign expire = 1'b0;
`endif

  always_comb begin
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_set_d  = 1'b0;
    idx_d      = idx_q;
    frag_d     = frag_q | (sync && (idx_q != '0));
    if (in_valid) begin
      if (eff_idx == LAST_IDX) begin
        out_data_d = merged;
        out_set_d  = 1'b1;
        acc_d      = '0;
        idx_d      = '0;
      end else begin
        acc_d = merged;
        idx_d = eff_idx + 1'b1;
      end
    end else if (sync) begin
      acc_d = '0;
      idx_d = '0;
    end else if (expire) begin
      acc_d  = '0;
      idx_d  = '0;
      frag_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= '0;
      out_data_q <= '0;
      out_set_q  <= 1'b0;
      idx_q      <= '0;
      frag_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_set_q  <= out_set_d;
      idx_q      <= idx_d;
      frag_q     <= frag_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_set    = out_set_q;
  assign busy       = (idx_q != '0);
  assign word_idx   = idx_q;
  assign frag_error = frag_q;

endmodule

// File: tb/tb_word_assembler.sv
// tb/tb_word_assembler.sv - directed self-checking bench for word_assembler

module tb_word_assembler;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        sync;
  logic [23:0] out_data;
  logic        out_set;
  logic        busy;
  logic [0:0]  word_idx;
  logic        frag_error;

  logic        b_valid;
  logic [15:0] b_data;
  logic        b_sync;
  logic [15:0] b_out_data;
  logic        b_out_set;
  logic        b_busy;
  logic [0:0]  b_word_idx;
  logic        b_frag_error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  word_assembler #(.bitwidth(24), .inwidth(16), .timeout(8)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .sync(sync),
    .out_data(out_data), .out_set(out_set), .busy(busy), .word_idx(word_idx),
    .frag_error(frag_error)
  );

  word_assembler #(.bitwidth(16), .inwidth(16), .timeout(8)) u_dut16 (
    .clock(clock), .reset(reset), .in_valid(b_valid), .in_data(b_data), .sync(b_sync),
    .out_data(b_out_data), .out_set(b_out_set), .busy(b_busy), .word_idx(b_word_idx),
    .frag_error(b_frag_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; sync = 1'b0;
    b_valid = 1'b0; b_data = '0; b_sync = 1'b0;
    step();
    step();
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_set", 32'(out_set), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_word_idx", 32'(word_idx), 32'h0);
    chk("rst_frag", 32'(frag_error), 32'h0);
    reset = 1'b0;

    // 1: basic two-word record
    feed(16'h3456);
    chk("t1_busy_mid", 32'(busy), 32'h1);
    chk("t1_idx_mid", 32'(word_idx), 32'h1);
    chk("t1_set_mid", 32'(out_set), 32'h0);
    feed(16'hAB12);
    chk("t1_set", 32'(out_set), 32'h1);
    chk("t1_data", 32'(out_data), 32'h123456);
    chk("t1_busy_end", 32'(busy), 32'h0);
    chk("t1_frag", 32'(frag_error), 32'h0);
    step();
    chk("t1_set_drop", 32'(out_set), 32'h0);
    chk("t1_data_hold", 32'(out_data), 32'h123456);

    // 2: back-to-back records every cycle
    in_valid = 1'b1;
    in_data = 16'h0001; step();
    chk("t2_set_a", 32'(out_set), 32'h0);
    in_data = 16'h0002; step();
    chk("t2_set_b", 32'(out_set), 32'h1);
    chk("t2_data_b", 32'(out_data), 32'h020001);
    in_data = 16'h0003; step();
    chk("t2_set_c", 32'(out_set), 32'h0);
    in_data = 16'h0004; step();
    chk("t2_set_d", 32'(out_set), 32'h1);
    chk("t2_data_d", 32'(out_data), 32'h040003);
    in_valid = 1'b0;
    step();

    // 3: sync mid-record
    feed(16'h1111);
    sync = 1'b1;
    feed(16'h2222);
    sync = 1'b0;
    chk("t3_frag", 32'(frag_error), 32'h1);
    chk("t3_idx", 32'(word_idx), 32'h1);
    chk("t3_set_mid", 32'(out_set), 32'h0);
    feed(16'h0033);
    chk("t3_set", 32'(out_set), 32'h1);
    chk("t3_data", 32'(out_data), 32'h332222);

    // 4: reset mid-record does not flag fragmentation
    do_reset();
    feed(16'h5555);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t4_idx_rst", 32'(word_idx), 32'h0);
    chk("t4_frag_rst", 32'(frag_error), 32'h0);
    feed(16'h6666);
    feed(16'h0077);
    chk("t4_set", 32'(out_set), 32'h1);
    chk("t4_data", 32'(out_data), 32'h776666);
    chk("t4_frag", 32'(frag_error), 32'h0);

    // 5: single-word configuration, strobe every cycle
    b_valid = 1'b1;
    b_data = 16'h000A; step();
    chk("t5_set_a", 32'(b_out_set), 32'h1);
    chk("t5_data_a", 32'(b_out_data), 32'h000A);
    b_data = 16'h000B; step();
    chk("t5_set_b", 32'(b_out_set), 32'h1);
    chk("t5_data_b", 32'(b_out_data), 32'h000B);
    b_data = 16'h000C; step();
    chk("t5_set_c", 32'(b_out_set), 32'h1);
    chk("t5_data_c", 32'(b_out_data), 32'h000C);
    chk("t5_busy", 32'(b_busy), 32'h0);
    b_valid = 1'b0; step();
    chk("t5_set_drop", 32'(b_out_set), 32'h0);

    // 6: idle timeout (or its absence)
    do_reset();
    feed(16'h1234);
    for (int i = 0; i < 7; i++) step();
    chk("t6_busy_pre", 32'(busy), 32'h1);
`ifdef ASSEMBLER_TIMEOUT_EN
    step();
    chk("t6_busy_exp", 32'(busy), 32'h0);
    chk("t6_frag_exp", 32'(frag_error), 32'h1);
    chk("t6_idx_exp", 32'(word_idx), 32'h0);
`else
    for (int i = 0; i < 93; i++) step();
    chk("t6_busy_hold", 32'(busy), 32'h1);
    chk("t6_frag_hold", 32'(frag_error), 32'h0);
    do_reset();
`endif
    feed(16'h0001);
    feed(16'h0002);
    chk("t6_set", 32'(out_set), 32'h1);
    chk("t6_data", 32'(out_data), 32'h020001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_assembler.md
Name: word_assembler

Overview:
- Upstream feeder for the 24-bit parameter holding buffers.
- Collects narrow host pipe words, `inwidth` bits each, into one `bitwidth`-bit word.
- When a word is complete, issues a one-cycle `out_set` strobe with `out_data` stable, to drive the holding buffer's data/set inputs directly.
- Tracks fragmentation errors caused by resync or stalled transfers.

Parameters:
- bitwidth, 24, assembled output word width.
- inwidth, 16, input word width (1..bitwidth).
- timeout, 1024, idle cycles before a partial word is abandoned; used only when ASSEMBLER_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_data holds a valid word this cycle.
- in_data  input  inwidth  input word.
- sync  input  1  start-of-record marker; restarts assembly at word 0.
- out_data  output  bitwidth  last completed word (registered).
- out_set  output  1  one-cycle strobe, out_data valid and new.
- busy  output  1  partial word held (word index != 0).
- word_idx  output  clog2(NWORDS) (min 1)  index of the next expected input word.
- frag_error  output  1  sticky: partial word was discarded.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock.
- NWORDS = ceil(bitwidth/inwidth). For defaults, NWORDS = 2.
- Reset values: out_data=0, out_set=0, busy=0, word_idx=0, frag_error=0. Internal accumulator=0, timeout counter=0.
- reset has priority over all inputs. Reset mid-assembly discards the partial word and does not set frag_error.
- Word order is little-endian: word k lands in accumulator bits [k*inwidth +: inwidth].
  - Last word: only the low (bitwidth-(NWORDS-1)*inwidth) bits are used; excess upper bits are ignored.
- On in_valid with word_idx < NWORDS-1: store the slice, word_idx++, busy=1.
- On in_valid with word_idx == NWORDS-1:
  - At the same edge, out_data <= accumulator merged with the final slice, and out_set <= 1.
  - word_idx <= 0, busy <= 0.
  - Latency: out_set and new out_data are visible the cycle after the final in_valid.
- out_set is high for exactly one cycle per completed word. out_data holds until the next completion.
- Throughput: in_valid may be asserted every cycle with no backpressure. If NWORDS == 1, out_set may be high on consecutive cycles.
- sync:
  - word_idx <= 0 and the partial accumulator is discarded.
  - If word_idx != 0 when sync is sampled, frag_error <= 1.
  - If sync and in_valid are high together, in_data is taken as word 0: word_idx becomes 1, or a completion occurs if NWORDS == 1.
- frag_error is cleared only by reset.
- Bits of the accumulator not yet written are undefined-free: the accumulator is cleared to 0 on completion, sync, and reset.

Optional Feature:
- Macro: ASSEMBLER_TIMEOUT_EN.
- Defined:
  - Idle counter increments each cycle while busy=1 and in_valid=0.
  - The counter resets on in_valid, sync, or completion.
  - When the counter reaches `timeout`: word_idx <= 0, accumulator <= 0, busy <= 0, frag_error <= 1, counter <= 0.
  - in_valid in the same cycle as expiry wins: the word is accepted and no timeout occurs.
- Not defined: no counter logic; a partial word persists indefinitely. The `timeout` parameter is ignored.

Test Plan (bitwidth=24, inwidth=16 unless stated):
1. in_data 0x3456 then 0xAB12 on consecutive cycles -> out_set pulses once, the cycle after 0xAB12; out_data=0x123456; busy back to 0; frag_error=0.
2. Back-to-back records 0x0001,0x0002,0x0003,0x0004 every cycle -> out_set pulses 2 cycles apart; out_data 0x020001 then 0x040003.
3. 0x1111, then sync+in_valid with 0x2222, then 0x0033 -> frag_error=1; out_data=0x332222.
4. reset asserted after first word 0x5555, then 0x6666,0x0077 -> no frag_error; out_data=0x776666.
5. bitwidth=16, inwidth=16, in_valid held 3 cycles with 0xA,0xB,0xC -> out_set high 3 consecutive cycles; out_data A, B, C.
6. ASSEMBLER_TIMEOUT_EN, timeout=8: word 0x1234, idle 8 cycles -> busy=0, frag_error=1. Then 0x0001,0x0002 -> out_data=0x020001. Without the macro, after 100 idle cycles busy is still 1.
